controle_iterativo: RTL and testbench
=====================================

CONTROLE_ITERATIVO -- requirements
Module: controle_iterativo

Interface
REQ-001 SHALL have parameter N_ITER, default 4, number of MUL/ADD passes per operation (legal range 1..255).
REQ-002 SHALL have parameter SEL_W, default 2, width of each mux select.
REQ-003 SHALL derive localparam CNT_W = clog2(N_ITER+1), width of the iteration counter.
REQ-004 SHALL have clock  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have start  in  1  request a new operation; sampled only in IDLE.
REQ-007 SHALL have hold  in  1  datapath stall; freezes the sequencer.
REQ-008 SHALL have abort  in  1  cancel the current operation.
REQ-009 SHALL have ack  in  1  consumer accepts the result.
REQ-010 SHALL have ready, valid, busy  out  1 each  in IDLE / result held / operation in progress.
REQ-011 SHALL have h, LX, LH, LS  out  1 each  datapath function select and register load enables.
REQ-012 SHALL have m0, m1, m2  out  SEL_W each  datapath mux selects.
REQ-013 SHALL have iter  out  CNT_W  index of the current pass.

Function
REQ-014 SHALL implement states IDLE, LOAD, MUL, ADD, FINAL, DONE.
REQ-015 Transitions SHALL be: IDLE->LOAD on start; LOAD->MUL; MUL->ADD; ADD->MUL while iter < N_ITER-1, else ADD->FINAL; FINAL->DONE; DONE->IDLE on ack.
REQ-016 iter SHALL clear in LOAD and increment on each ADD->MUL transition; it SHALL never exceed N_ITER-1.
REQ-017 Outputs SHALL be decoded combinationally from the state as listed below; any signal not listed is 0.
- IDLE: ready=1.
- LOAD: LX=1, LH=1, h=1, m1=1.
- MUL: LH=1, h=1, m0=1, m2=3.
- ADD: LS=1, h=1, m0=2.
- FINAL: LS=1, m1=3, m2=2.
- DONE: valid=1.
REQ-018 busy SHALL be 1 in LOAD, MUL, ADD and FINAL.
REQ-019 While hold=1 the state and iter SHALL be frozen, and LX, LH and LS SHALL be forced to 0; h and the mux selects keep their decoded values.
REQ-020 abort=1 in any non-IDLE state SHALL move to IDLE at the next edge and clear iter.
REQ-021 Priority SHALL be: abort > hold > normal transition.
REQ-022 start SHALL be ignored outside IDLE, including in DONE.
REQ-023 valid SHALL stay 1 until ack; ack outside DONE SHALL be ignored.
REQ-024 Latency SHALL be 2*N_ITER+3 edges from the edge sampling start to the first valid=1 cycle, with no hold active.
REQ-025 With N_ITER=1, the sequence SHALL be LOAD, MUL, ADD, FINAL, DONE.

Reset
REQ-026 reset=0 SHALL force IDLE and iter=0 immediately, regardless of clock.
REQ-027 While reset=0 the outputs SHALL be: ready=1; valid, busy, h, LX, LH, LS = 0; m0, m1, m2 = 0.
REQ-028 Reset deasserted mid-operation SHALL leave the block in IDLE, with no partial result and no valid.

Structure
REQ-029 The state encoding (3-bit: IDLE=0 .. DONE=5) and the select codes SHALL be constants in a shared package used by control and datapath.
REQ-030 The iteration counter SHALL be the sub-module contador_iteracao, with clear, enable and terminal-count output.

Verification
REQ-031 N_ITER=4, start pulse -> states LOAD, (MUL, ADD)x4, FINAL, DONE; valid at edge 11; iter runs 0..3.
REQ-032 In DONE, hold ack=0 for 5 cycles -> valid stays 1; ack=1 -> ready=1 at the next edge.
REQ-033 hold=1 for 3 cycles during MUL with iter=2 -> state and iter unchanged, LH=0; then resumes, valid delayed by exactly 3 cycles.
REQ-034 abort=1 in ADD with iter=1, hold=1 at the same time -> IDLE next edge, iter=0, valid never asserted.
REQ-035 reset=0 asserted mid-cycle in FINAL -> ready=1 and LS=0 without a clock edge; start in DONE ignored.
REQ-036 N_ITER=1 -> valid at edge 5; N_ITER=255 -> valid at edge 513, iter maximum 254.

Source files
------------

// File: rtl/controle_iterativo_pkg.sv
// Shared constants for the iterative MUL/ADD sequencer and its datapath.
// Holds the 3-bit state encoding, the mux select codes driven in each
// state, and the helper that sizes the iteration counter.
package controle_iterativo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MUL   = 3'd2,
    ST_ADD   = 3'd3,
    ST_FINAL = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Datapath mux select codes, one per state that drives a nonzero value.
  localparam int unsigned SEL_M1_LOAD  = 1;
  localparam int unsigned SEL_M0_MUL   = 1;
  localparam int unsigned SEL_M2_MUL   = 3;
  localparam int unsigned SEL_M0_ADD   = 2;
  localparam int unsigned SEL_M1_FINAL = 3;
  localparam int unsigned SEL_M2_FINAL = 2;

  // Width needed to hold the values 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/controle_iterativo_contador.sv
// Iteration counter for the sequencer.
// Ports:
//   clock_i  - clock, rising edge
//   reset_ni - asynchronous active-low reset (count -> 0)
//   clr_i    - synchronous clear, wins over en_i
//   en_i     - advance by one; saturates at the terminal count
//   cnt_o    - current pass index
//   tc_o     - high when cnt_o equals N_ITER-1
module contador_iteracao #(
  parameter int unsigned N_ITER = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_ITER - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_last;

  assign at_last = (cnt_q == LAST);

  // Saturating at LAST keeps the index within 0..N_ITER-1 even if en_i
  // were raised on the final pass.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && !at_last)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = at_last;

endmodule

// File: rtl/controle_iterativo.sv
// Sequencer for an iterative MUL/ADD datapath: LOAD, N_ITER x (MUL, ADD),
// FINAL, then holds the result in DONE until acknowledged.
// Ports:
//   clock_i, reset_ni        - clock and asynchronous active-low reset
//   start_i                  - begin an operation (IDLE only)
//   hold_i                   - stall: freezes state/iter, masks load enables
//   abort_i                  - cancel, back to IDLE with iter cleared
//   ack_i                    - consumer takes the result (DONE only)
//   ready_o, valid_o, busy_o - IDLE / DONE / LOAD..FINAL
//   h_o, LX_o, LH_o, LS_o    - datapath function select and load enables
//   m0_o, m1_o, m2_o         - datapath mux selects
//   iter_o                   - current pass index
//
// state | meaning
// IDLE  | waiting for start, ready=1
// LOAD  | load operands, clear pass index
// MUL   | multiply step of the current pass
// ADD   | accumulate step; loops to MUL until the last pass
// FINAL | final accumulation into the result register
// DONE  | result held, valid=1 until ack
module controle_iterativo
  import controle_iterativo_pkg::*;
#(
  parameter  int unsigned N_ITER = 4,
  parameter  int unsigned SEL_W  = 2,
  localparam int unsigned CNT_W  = cnt_width(N_ITER)
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             start_i,
  input  logic             hold_i,
  input  logic             abort_i,
  input  logic             ack_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             h_o,
  output logic             LX_o,
  output logic             LH_o,
  output logic             LS_o,
  output logic [SEL_W-1:0] m0_o,
  output logic [SEL_W-1:0] m1_o,
  output logic [SEL_W-1:0] m2_o,
  output logic [CNT_W-1:0] iter_o
);

  state_e           state_q;
  logic             abort_act, advance, cnt_clr, cnt_en, cnt_tc;
  logic [CNT_W-1:0] iter_cnt;

  // abort wins over hold; hold wins over the normal transition.
  assign abort_act = abort_i && (state_q != ST_IDLE);
  assign advance   = !abort_act && !hold_i;

  // Clear on entry to LOAD so the index reads 0 during LOAD itself.
  assign cnt_clr = abort_act ||
                   (advance && ((state_q == ST_IDLE && start_i) || state_q == ST_LOAD));
  assign cnt_en  = advance && (state_q == ST_ADD) && !cnt_tc;

  contador_iteracao #(
    .N_ITER (N_ITER),
    .CNT_W  (CNT_W)
  ) u_contador (
    .clock_i  (clock_i),
    .reset_ni (reset_ni),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .cnt_o    (iter_cnt),
    .tc_o     (cnt_tc)
  );

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
    end else if (abort_act) begin
      state_q <= ST_IDLE;
    end else if (!hold_i) begin
      case (state_q)
        ST_IDLE:  if (start_i) state_q <= ST_LOAD;
        ST_LOAD:  state_q <= ST_MUL;
        ST_MUL:   state_q <= ST_ADD;
        ST_ADD:   state_q <= cnt_tc ? ST_FINAL : ST_MUL;
        ST_FINAL: state_q <= ST_DONE;
        ST_DONE:  if (ack_i) state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Outputs follow the state directly so reset takes effect without a clock.
  always_comb begin
    ready_o = 1'b0;
    valid_o = 1'b0;
    busy_o  = 1'b0;
    h_o     = 1'b0;
    LX_o    = 1'b0;
    LH_o    = 1'b0;
    LS_o    = 1'b0;
    m0_o    = '0;
    m1_o    = '0;
    m2_o    = '0;
    case (state_q)
      ST_IDLE: ready_o = 1'b1;
      ST_LOAD: begin
        busy_o = 1'b1;
        LX_o   = 1'b1;
        LH_o   = 1'b1;
        h_o    = 1'b1;
        m1_o   = SEL_W'(SEL_M1_LOAD);
      end
      ST_MUL: begin
        busy_o = 1'b1;
        LH_o   = 1'b1;
        h_o    = 1'b1;
        m0_o   = SEL_W'(SEL_M0_MUL);
        m2_o   = SEL_W'(SEL_M2_MUL);
      end
      ST_ADD: begin
        busy_o = 1'b1;
        LS_o   = 1'b1;
        h_o    = 1'b1;
        m0_o   = SEL_W'(SEL_M0_ADD);
      end
      ST_FINAL: begin
        busy_o = 1'b1;
        LS_o   = 1'b1;
        m1_o   = SEL_W'(SEL_M1_FINAL);
        m2_o   = SEL_W'(SEL_M2_FINAL);
      end
      ST_DONE: valid_o = 1'b1;
      default: ready_o = 1'b1;
    endcase
    // A stalled datapath must not capture anything; selects stay as decoded.
    if (hold_i) begin
      LX_o = 1'b0;
      LH_o = 1'b0;
      LS_o = 1'b0;
    end
  end

  assign iter_o = iter_cnt;

endmodule

// File: tb/tb_controle_iterativo.sv
// Bench for controle_iterativo: a step-index reference model predicts the
// outputs every cycle, and a latency scoreboard pairs each issued operation
// with the first valid it produces. Extra instances cover N_ITER=1 and 255.
module tb_controle_iterativo;

  localparam int N  = 4;
  localparam int W4 = $clog2(N + 1);

  typedef struct packed {
    logic       ready, valid, busy, h, lx, lh, ls;
    logic [1:0] m0, m1, m2;
  } outs_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start, hold, abort, ack;
  logic ready4, valid4, busy4, h4, lx4, lh4, ls4;
  logic [1:0] m0_4, m1_4, m2_4;
  logic [W4-1:0] iter4;

  logic start1, ack1, start255, ack255, zero_in;
  logic ready1, valid1, busy1, h1, lx1, lh1, ls1;
  logic [1:0] m0_1, m1_1, m2_1;
  logic [0:0] iter1;
  logic ready255, valid255, busy255, h255, lx255, lh255, ls255;
  logic [1:0] m0_255, m1_255, m2_255;
  logic [7:0] iter255;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  controle_iterativo #(.N_ITER(N), .SEL_W(2)) dut (
    .clock_i(clk), .reset_ni(rst_n), .start_i(start), .hold_i(hold),
    .abort_i(abort), .ack_i(ack), .ready_o(ready4), .valid_o(valid4),
    .busy_o(busy4), .h_o(h4), .LX_o(lx4), .LH_o(lh4), .LS_o(ls4),
    .m0_o(m0_4), .m1_o(m1_4), .m2_o(m2_4), .iter_o(iter4));

  controle_iterativo #(.N_ITER(1), .SEL_W(2)) dut1 (
    .clock_i(clk), .reset_ni(rst_n), .start_i(start1), .hold_i(zero_in),
    .abort_i(zero_in), .ack_i(ack1), .ready_o(ready1), .valid_o(valid1),
    .busy_o(busy1), .h_o(h1), .LX_o(lx1), .LH_o(lh1), .LS_o(ls1),
    .m0_o(m0_1), .m1_o(m1_1), .m2_o(m2_1), .iter_o(iter1));

  controle_iterativo #(.N_ITER(255), .SEL_W(2)) dut255 (
    .clock_i(clk), .reset_ni(rst_n), .start_i(start255), .hold_i(zero_in),
    .abort_i(zero_in), .ack_i(ack255), .ready_o(ready255), .valid_o(valid255),
    .busy_o(busy255), .h_o(h255), .LX_o(lx255), .LH_o(lh255), .LS_o(ls255),
    .m0_o(m0_255), .m1_o(m1_255), .m2_o(m2_255), .iter_o(iter255));

  // Reference model: an operation is a sequence of 2N+2 steps indexed by k
  // (0 = load, odd = multiply, even = accumulate, 2N+1 = final), then done.
  bit m_busy, m_done, m_started, m_iter_zero;
  int mk;
  int edge_cnt = 0;
  int lat_q[$];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; mk <= 0; m_started <= 1'b0; m_iter_zero <= 1'b1;
    end else begin
      m_started <= 1'b0;
      if ((m_busy || m_done) && abort) begin
        m_busy <= 1'b0; m_done <= 1'b0; m_iter_zero <= 1'b1;
      end else if (hold) begin
      end else if (m_busy) begin
        if (mk == 2*N + 1) begin m_busy <= 1'b0; m_done <= 1'b1; end
        else mk <= mk + 1;
      end else if (m_done) begin
        if (ack) m_done <= 1'b0;
      end else if (start) begin
        m_busy <= 1'b1; mk <= 0; m_started <= 1'b1; m_iter_zero <= 1'b0;
      end
    end
  end

  function automatic outs_t exp_outs(bit b, bit d, int k, bit hld);
    outs_t o = '0;
    if (!b && !d) o.ready = 1'b1;
    else if (d) o.valid = 1'b1;
    else begin
      o.busy = 1'b1;
      if (k == 0) begin o.lx = 1; o.lh = 1; o.h = 1; o.m1 = 2'd1; end
      else if (k == 2*N + 1) begin o.ls = 1; o.m1 = 2'd3; o.m2 = 2'd2; end
      else if (k % 2 == 1) begin o.lh = 1; o.h = 1; o.m0 = 2'd1; o.m2 = 2'd3; end
      else begin o.ls = 1; o.h = 1; o.m0 = 2'd2; end
      if (hld) begin o.lx = 0; o.lh = 0; o.ls = 0; end
    end
    return o;
  endfunction

  // -1 means the pass index is not constrained in this state.
  function automatic int exp_iter(bit b, bit d, int k, bit z);
    if (b) begin
      if (k == 0) return 0;
      if (k == 2*N + 1) return N - 1;
      return (k % 2 == 1) ? (k - 1) / 2 : (k - 2) / 2;
    end
    if (d) return N - 1;
    return z ? 0 : -1;
  endfunction

  task automatic check_cycle();
    outs_t act, expv;
    int ei;
    act  = {ready4, valid4, busy4, h4, lx4, lh4, ls4, m0_4, m1_4, m2_4};
    expv = exp_outs(m_busy, m_done, mk, hold);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL outputs edge=%0d got=%h expected=%h", edge_cnt, act, expv);
    end
    ei = exp_iter(m_busy, m_done, mk, m_iter_zero);
    if (ei >= 0) begin
      checks++;
      if (int'(iter4) != ei) begin
        errors++;
        $display("FAIL iter edge=%0d got=%0d expected=%0d", edge_cnt, iter4, ei);
      end
    end
  endtask

  task automatic check_val(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  // Monitor: per-cycle output check plus latency scoreboard.
  initial begin
    bit prev_valid = 1'b0;
    int t_start = 0;
    int want;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        check_cycle();
        if (m_started) t_start = edge_cnt;
        if (valid4 && !prev_valid) begin
          checks++;
          if (lat_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid edge=%0d got=1 expected=0", edge_cnt);
          end else begin
            want = lat_q.pop_front();
            if (edge_cnt - t_start + 1 != want) begin
              errors++;
              $display("FAIL latency got=%0d expected=%0d", edge_cnt - t_start + 1, want);
            end
          end
        end
      end
      prev_valid = valid4;
    end
  end

  task automatic run_normal(int hold_pct, int ack_wait, bit directed_hold);
    bit plan[$];
    int adv = 0;
    int nh = 0;
    while (adv < 2*N + 2) begin
      bit b;
      if (directed_hold) b = (adv == 5) && (nh < 3);
      else b = ($urandom_range(0, 99) < hold_pct);
      plan.push_back(b);
      if (b) nh++; else adv++;
    end
    lat_q.push_back(2*N + 3 + nh);
    @(negedge clk); start = 1; hold = 0; ack = 0; abort = 0;
    foreach (plan[i]) begin
      @(negedge clk);
      hold = plan[i];
      start = 1'($urandom_range(0, 1));
      ack = 1'($urandom_range(0, 1));
    end
    for (int w = 0; w < ack_wait; w++) begin
      @(negedge clk); hold = 0; ack = 0; start = 1'($urandom_range(0, 1));
    end
    @(negedge clk); hold = 0; ack = 1; start = 0;
    @(negedge clk); ack = 0;
  endtask

  task automatic run_abort();
    bit found = 0;
    @(negedge clk); start = 1; hold = 0; abort = 0; ack = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      start = 0;
      if (m_busy && mk == 4) begin abort = 1; hold = 1; found = 1; break; end
      hold = 0;
    end
    check_val("abort_reached_add_iter1", int'(found), 1);
    @(negedge clk); abort = 0; hold = 0;
    check_val("abort_ready", int'(ready4), 1);
    check_val("abort_iter", int'(iter4), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic run_reset_final();
    bit found = 0;
    @(negedge clk); start = 1; hold = 0; abort = 0; ack = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      start = 0;
      if (m_busy && mk == 2*N + 1) begin found = 1; break; end
    end
    check_val("reset_reached_final", int'(found), 1);
    #2 rst_n = 0;
    #1;
    check_val("async_reset_ready", int'(ready4), 1);
    check_val("async_reset_ls", int'(ls4), 0);
    check_val("async_reset_busy_valid", int'({busy4, valid4}), 0);
    check_val("async_reset_iter", int'(iter4), 0);
    start = 1;
    repeat (2) @(negedge clk);
    rst_n = 1; start = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] seq1 [5];
    int lat1 = 0, lat255 = 0, imax = 0;
    seq1[0] = 5'b11100; seq1[1] = 5'b10100; seq1[2] = 5'b10010;
    seq1[3] = 5'b00010; seq1[4] = 5'b00001;

    rst_n = 0; start = 0; hold = 0; abort = 0; ack = 0;
    start1 = 0; ack1 = 0; start255 = 0; ack255 = 0; zero_in = 0;
    #2;
    check_val("reset_outputs",
              int'({ready4, valid4, busy4, h4, lx4, lh4, ls4, m0_4, m1_4, m2_4}),
              int'(exp_outs(1'b0, 1'b0, 0, 1'b0)));
    check_val("reset_iter", int'(iter4), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    run_normal(0, 0, 1'b0);
    run_normal(0, 5, 1'b0);
    run_normal(0, 1, 1'b1);
    run_abort();
    run_reset_final();
    for (int op = 0; op < 20; op++)
      run_normal($urandom_range(0, 40), $urandom_range(0, 4), 1'b0);

    @(negedge clk); start1 = 1; start255 = 1;
    for (int e = 1; e <= 600; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) begin start1 = 0; start255 = 0; end
      if (e <= 5) check_val($sformatf("n1_step%0d", e), int'({h1, lx1, lh1, ls1, valid1}), int'(seq1[e-1]));
      if (lat1 == 0 && valid1) lat1 = e;
      if (lat255 == 0 && valid255) lat255 = e;
      if (int'(iter255) > imax) imax = int'(iter255);
      if (lat1 != 0 && lat255 != 0) break;
    end
    check_val("n1_latency", lat1, 5);
    check_val("n255_latency", lat255, 513);
    check_val("n255_iter_max", imax, 254);
    @(negedge clk); ack1 = 1; ack255 = 1;
    @(negedge clk); ack1 = 0; ack255 = 0;
    check_val("n1_ready_after_ack", int'(ready1), 1);
    check_val("n255_ready_after_ack", int'(ready255), 1);

    repeat (3) @(negedge clk);
    check_val("scoreboard_drained", lat_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
